shared_match_pe_arbiter: RTL and testbench
==========================================

// Module: shared_match_pe_arbiter
// PURPOSE
//   Shares one match PE among NUM_REQ job-PE requesters. Round-robin grant of match requests.
//   Stamps each request with a requester-ID tag and caps in-flight requests per requester.
//   Routes match responses back to the owning requester by tag.
//   Sits between the job-PE array and a single match PE, in place of a mesh hop when the PE is local.
// PARAMETERS
//   NUM_REQ          4  number of requesters (power of two, >=2)
//   NUM_REQ_LOG2     2  log2(NUM_REQ); must be <= `NUM_JOB_PE_LOG2
//   MAX_OUTSTANDING  4  max in-flight requests per requester (1..15)
// PORTS
//   clk                     in   1                            clock
//   rst                     in   1                            synchronous, active-high reset
//   req_valid               in   NUM_REQ                      per-requester request valid
//   req_ready               out  NUM_REQ                      per-requester request accepted
//   req_head_addr           in   NUM_REQ*`ADDR_WIDTH          packed, requester i at [i*W +: W]
//   req_history_addr        in   NUM_REQ*`ADDR_WIDTH          packed, as above
//   req_local_tag           in   NUM_REQ*`LAZY_LEN_LOG2       per-requester lazy slot tag
//   match_req_valid         out  1                            to match PE
//   match_req_ready         in   1
//   match_req_head_addr     out  `ADDR_WIDTH
//   match_req_history_addr  out  `ADDR_WIDTH
//   match_req_tag           out  `NUM_JOB_PE_LOG2+`LAZY_LEN_LOG2  {local_tag, zero-extended requester id}
//   match_resp_valid        in   1                            from match PE
//   match_resp_ready        out  1
//   match_resp_tag          in   `NUM_JOB_PE_LOG2+`LAZY_LEN_LOG2
//   match_resp_match_len    in   `MATCH_LEN_WIDTH
//   resp_valid              out  NUM_REQ                      one-hot response to owner
//   resp_ready              in   NUM_REQ
//   resp_local_tag          out  `LAZY_LEN_LOG2                broadcast; valid qualifies
//   resp_match_len          out  `MATCH_LEN_WIDTH              broadcast
// BEHAVIOUR
//   Reset: match_req_valid=0, match_req_* fields=0, RR pointer=0, all outstanding counters=0.
//   Reset is honoured mid-operation; in-flight responses arriving after reset are not expected
//   (the match PE is reset in the same cycle).
//   Eligibility: eligible[i] = req_valid[i] && cnt[i] < MAX_OUTSTANDING.
//   Request path: one output register (valid/data). It may load when !match_req_valid or match_req_ready.
//   Load: grant the first eligible i at or after the RR pointer (wrapping); req_ready[i]=1 for that i only;
//     the register captures the addresses and tag; the pointer becomes (i+1) mod NUM_REQ.
//   req_ready is combinational from eligibility and the load condition. At most one bit is set per cycle.
//   Throughput is 1 request/cycle; latency from req handshake to match_req_valid is 1 cycle.
//   match_req_* fields are held stable while valid && !ready.
//   Response path: combinational demux. id = match_resp_tag[NUM_REQ_LOG2-1:0].
//     resp_valid[id] = match_resp_valid; match_resp_ready = resp_ready[id].
//     Local tag = match_resp_tag[MSBs]. Zero latency, no buffering.
//   Counters: cnt[i]++ on grant of i; cnt[i]-- on a response handshake for i.
//     Both in the same cycle -> unchanged.
//   Requester at MAX_OUTSTANDING: req_ready[i]=0 until a response drains it. The next eligible requester
//     is granted that cycle (no bubble).
//   Errors (simulation only): response for a requester with cnt=0 -> $fatal;
//     id >= NUM_REQ -> $fatal.
// CONFIGURATION
//   SHARED_MATCH_ARB_STATS_EN defined: adds outputs stat_grant_cnt (NUM_REQ*32)
//     and stat_stall_cnt (NUM_REQ*32).
//     stat_grant_cnt[i]: grants to i. stat_stall_cnt[i]: cycles with req_valid[i] and not granted.
//     Both wrap at 2^32 and are cleared by rst.
//   Not defined: those ports and counters are absent. Other behaviour is identical.
// STRUCTURE
//   Shared package (parameters.vh / util.vh): tag-pack/unpack macros {local_tag, pe_id}, and the
//     MAX_OUTSTANDING counter width macro.
//   Sub-module rr_arbiter (NUM_REQ): inputs eligible and advance; outputs one-hot grant and index.
//     It owns the pointer. The rest is inline.
// TESTING
//   1. Single requester 2 issues 3 requests, match_req_ready=1.
//      -> match_req_tag low bits = 2 each, 1-cycle latency, cnt[2]=3.
//   2. All 4 requesters valid continuously, ready=1.
//      -> grant order 0,1,2,3,0,...; 1 grant/cycle; no requester starved.
//   3. Requester 1 issues 4 with no responses (MAX_OUTSTANDING=4).
//      -> req_ready[1]=0 on the 5th. A response tag {x,1} handshake -> cnt=3, next grant allowed.
//   4. match_req_ready held 0 for 5 cycles.
//      -> match_req_* stable, req_ready all 0, no counter change.
//   5. Same-cycle grant and response for requester 3 -> cnt[3] unchanged.
//      With resp_ready[3]=0 -> match_resp_ready=0 and no decrement.
//   6. rst asserted with 2 requests in flight -> next cycle match_req_valid=0, all cnt=0, pointer=0.
//      With SHARED_MATCH_ARB_STATS_EN, scenario 2 for 8 cycles -> stat_grant_cnt[i]=2 each.

Source files
------------

// File: rtl/shared_match_pe_arbiter_pkg.sv
// Shared widths and tag pack/unpack helpers for the match-PE arbiter.
// A tag is {local_tag, pe_id}; pe_id is the zero-extended requester index.
package shared_match_pe_arbiter_pkg;

    localparam int ADDR_WIDTH      = 32;
    localparam int LAZY_LEN_LOG2   = 2;
    localparam int NUM_JOB_PE_LOG2 = 3;
    localparam int MATCH_LEN_WIDTH = 8;
    localparam int TAG_WIDTH       = NUM_JOB_PE_LOG2 + LAZY_LEN_LOG2;
    // Outstanding counters hold up to 15 in-flight requests.
    localparam int CNT_WIDTH       = 4;

    function automatic logic [TAG_WIDTH-1:0] pack_tag(
        input logic [LAZY_LEN_LOG2-1:0]   local_tag,
        input logic [NUM_JOB_PE_LOG2-1:0] pe_id
    );
        return {local_tag, pe_id};
    endfunction

    function automatic logic [LAZY_LEN_LOG2-1:0] tag_local(input logic [TAG_WIDTH-1:0] tag);
        return tag[TAG_WIDTH-1 -: LAZY_LEN_LOG2];
    endfunction

    function automatic logic [NUM_JOB_PE_LOG2-1:0] tag_pe_id(input logic [TAG_WIDTH-1:0] tag);
        return tag[NUM_JOB_PE_LOG2-1:0];
    endfunction

endpackage

// File: rtl/shared_match_pe_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first eligible index at or after the pointer,
// and moves the pointer past the winner whenever advance is high and a grant exists.
module rr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_REQ_LOG2 = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      eligible,
    input  logic                    advance,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ_LOG2-1:0] grant_idx,
    output logic                    grant_valid
);

    logic [NUM_REQ_LOG2-1:0] ptr;
    logic [NUM_REQ_LOG2-1:0] cand;

    // NUM_REQ is a power of two, so pointer arithmetic wraps naturally.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ptr + NUM_REQ_LOG2'(k);
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && grant_valid) begin
            ptr <= grant_idx + NUM_REQ_LOG2'(1);
        end
    end

endmodule

// File: rtl/shared_match_pe_arbiter.sv
// Shares one match PE among NUM_REQ requesters: round-robin request mux with
// per-requester in-flight caps, and a zero-latency tag-routed response demux.
// Optional SHARED_MATCH_ARB_STATS_EN adds per-requester grant/stall counters.
import shared_match_pe_arbiter_pkg::*;

module shared_match_pe_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int NUM_REQ_LOG2    = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_head_addr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_history_addr,
    input  logic [NUM_REQ*LAZY_LEN_LOG2-1:0]   req_local_tag,
    output logic                               match_req_valid,
    input  logic                               match_req_ready,
    output logic [ADDR_WIDTH-1:0]              match_req_head_addr,
    output logic [ADDR_WIDTH-1:0]              match_req_history_addr,
    output logic [TAG_WIDTH-1:0]               match_req_tag,
    input  logic                               match_resp_valid,
    output logic                               match_resp_ready,
    input  logic [TAG_WIDTH-1:0]               match_resp_tag,
    input  logic [MATCH_LEN_WIDTH-1:0]         match_resp_match_len,
    output logic [NUM_REQ-1:0]                 resp_valid,
    input  logic [NUM_REQ-1:0]                 resp_ready,
    output logic [LAZY_LEN_LOG2-1:0]           resp_local_tag,
    output logic [MATCH_LEN_WIDTH-1:0]         resp_match_len
`ifdef SHARED_MATCH_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]              stat_grant_cnt,
    output logic [NUM_REQ*32-1:0]              stat_stall_cnt
`endif
);

    logic                    load;
    logic                    grant_valid;
    logic [NUM_REQ-1:0]      eligible;
    logic [NUM_REQ-1:0]      grant;
    logic [NUM_REQ-1:0]      dec_vec;
    logic [NUM_REQ_LOG2-1:0] grant_idx;
    logic [NUM_REQ_LOG2-1:0] resp_id;
    logic                    resp_fire;
    logic [CNT_WIDTH-1:0]    cnt [NUM_REQ];

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (cnt[i] < CNT_WIDTH'(MAX_OUTSTANDING));
        end
    end

    assign load      = !match_req_valid || match_req_ready;
    assign req_ready = load ? grant : '0;

    rr_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .NUM_REQ_LOG2 (NUM_REQ_LOG2)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst         (rst),
        .eligible    (eligible),
        .advance     (load),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Fields only move on a grant, so they stay stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_req_valid        <= 1'b0;
            match_req_head_addr    <= '0;
            match_req_history_addr <= '0;
            match_req_tag          <= '0;
        end else if (load) begin
            match_req_valid <= grant_valid;
            if (grant_valid) begin
                match_req_head_addr    <= req_head_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                match_req_history_addr <= req_history_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                match_req_tag          <= pack_tag(req_local_tag[grant_idx*LAZY_LEN_LOG2 +: LAZY_LEN_LOG2],
                                                   NUM_JOB_PE_LOG2'(grant_idx));
            end
        end
    end

    assign resp_id          = match_resp_tag[NUM_REQ_LOG2-1:0];
    assign resp_local_tag   = tag_local(match_resp_tag);
    assign resp_match_len   = match_resp_match_len;
    assign match_resp_ready = resp_ready[resp_id];
    assign resp_fire        = match_resp_valid && match_resp_ready;

    always_comb begin
        resp_valid          = '0;
        resp_valid[resp_id] = match_resp_valid;
        dec_vec             = '0;
        dec_vec[resp_id]    = resp_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && !dec_vec[i]) begin
                    cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                end else if (!req_ready[i] && dec_vec[i]) begin
                    cnt[i] <= cnt[i] - CNT_WIDTH'(1);
                end
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && match_resp_valid) begin
            assert (int'(tag_pe_id(match_resp_tag)) < NUM_REQ)
                else $fatal(1, "match response for nonexistent requester id %0d", tag_pe_id(match_resp_tag));
            if (match_resp_ready) begin
                assert (cnt[resp_id] != '0)
                    else $fatal(1, "match response for requester %0d with nothing in flight", resp_id);
            end
        end
    end
`endif

`ifdef SHARED_MATCH_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grant_cnt <= '0;
            stat_stall_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    stat_grant_cnt[i*32 +: 32] <= stat_grant_cnt[i*32 +: 32] + 32'd1;
                end
                if (req_valid[i] && !req_ready[i]) begin
                    stat_stall_cnt[i*32 +: 32] <= stat_stall_cnt[i*32 +: 32] + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_shared_match_pe_arbiter.sv
// Self-checking bench for shared_match_pe_arbiter: directed scenarios then random
// traffic, all compared against a cycle-level reference model kept here.
module tb_shared_match_pe_arbiter;
    import shared_match_pe_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int MO = 4;

    logic                             clk = 1'b0;
    logic                             rst = 1'b1;
    logic [NR-1:0]                    req_valid = '0;
    logic [NR-1:0]                    req_ready;
    logic [NR*ADDR_WIDTH-1:0]         req_head_addr = '0;
    logic [NR*ADDR_WIDTH-1:0]         req_history_addr = '0;
    logic [NR*LAZY_LEN_LOG2-1:0]      req_local_tag = '0;
    logic                             match_req_valid;
    logic                             match_req_ready = 1'b0;
    logic [ADDR_WIDTH-1:0]            match_req_head_addr;
    logic [ADDR_WIDTH-1:0]            match_req_history_addr;
    logic [TAG_WIDTH-1:0]             match_req_tag;
    logic                             match_resp_valid = 1'b0;
    logic                             match_resp_ready;
    logic [TAG_WIDTH-1:0]             match_resp_tag = '0;
    logic [MATCH_LEN_WIDTH-1:0]       match_resp_match_len = '0;
    logic [NR-1:0]                    resp_valid;
    logic [NR-1:0]                    resp_ready = '0;
    logic [LAZY_LEN_LOG2-1:0]         resp_local_tag;
    logic [MATCH_LEN_WIDTH-1:0]       resp_match_len;
`ifdef SHARED_MATCH_ARB_STATS_EN
    logic [NR*32-1:0]                 stat_grant_cnt;
    logic [NR*32-1:0]                 stat_stall_cnt;
`endif

    shared_match_pe_arbiter #(
        .NUM_REQ         (NR),
        .NUM_REQ_LOG2    (2),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .req_valid              (req_valid),
        .req_ready              (req_ready),
        .req_head_addr          (req_head_addr),
        .req_history_addr       (req_history_addr),
        .req_local_tag          (req_local_tag),
        .match_req_valid        (match_req_valid),
        .match_req_ready        (match_req_ready),
        .match_req_head_addr    (match_req_head_addr),
        .match_req_history_addr (match_req_history_addr),
        .match_req_tag          (match_req_tag),
        .match_resp_valid       (match_resp_valid),
        .match_resp_ready       (match_resp_ready),
        .match_resp_tag         (match_resp_tag),
        .match_resp_match_len   (match_resp_match_len),
        .resp_valid             (resp_valid),
        .resp_ready             (resp_ready),
        .resp_local_tag         (resp_local_tag),
        .resp_match_len         (resp_match_len)
`ifdef SHARED_MATCH_ARB_STATS_EN
        ,
        .stat_grant_cnt         (stat_grant_cnt),
        .stat_stall_cnt         (stat_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: in-flight counts, RR pointer, output register contents.
    int                        m_cnt [NR];
    int                        m_ptr;
    bit                        m_valid;
    logic [ADDR_WIDTH-1:0]     m_head;
    logic [ADDR_WIDTH-1:0]     m_hist;
    logic [TAG_WIDTH-1:0]      m_tag;
    int unsigned               m_sg [NR];
    int unsigned               m_ss [NR];

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_cnt[i] = 0;
            m_sg[i]  = 0;
            m_ss[i]  = 0;
        end
        m_ptr   = 0;
        m_valid = 0;
        m_head  = '0;
        m_hist  = '0;
        m_tag   = '0;
    endtask

    // One clock: drive inputs, compare at the falling edge, then advance the model.
    task automatic step(input logic [NR-1:0] v, input bit mrr, input bit rsp, input int rid,
                        input logic [NR-1:0] rrdy);
        logic [ADDR_WIDTH-1:0]    heads [NR];
        logic [ADDR_WIDTH-1:0]    hists [NR];
        logic [LAZY_LEN_LOG2-1:0] lts   [NR];
        logic [LAZY_LEN_LOG2-1:0] rlt;
        logic [MATCH_LEN_WIDTH-1:0] rlen;
        int  g;
        bit  load;
        for (int i = 0; i < NR; i++) begin
            heads[i] = $urandom;
            hists[i] = $urandom;
            lts[i]   = LAZY_LEN_LOG2'($urandom);
            req_head_addr[i*ADDR_WIDTH +: ADDR_WIDTH]          = heads[i];
            req_history_addr[i*ADDR_WIDTH +: ADDR_WIDTH]       = hists[i];
            req_local_tag[i*LAZY_LEN_LOG2 +: LAZY_LEN_LOG2]    = lts[i];
        end
        rlt  = LAZY_LEN_LOG2'($urandom);
        rlen = MATCH_LEN_WIDTH'($urandom);
        req_valid            = v;
        match_req_ready      = mrr;
        match_resp_valid     = rsp;
        match_resp_tag       = {rlt, NUM_JOB_PE_LOG2'(rid)};
        match_resp_match_len = rlen;
        resp_ready           = rrdy;

        load = !m_valid || mrr;
        g = -1;
        if (load) begin
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_ptr + k) % NR;
                if (g < 0 && v[i] && m_cnt[i] < MO) g = i;
            end
        end

        #4;
        if (!rst) begin
            check("req_ready", 64'(req_ready), (g >= 0) ? 64'(1) << g : 64'(0));
            check("match_req_valid", 64'(match_req_valid), 64'(m_valid));
            check("match_req_head_addr", 64'(match_req_head_addr), 64'(m_head));
            check("match_req_history_addr", 64'(match_req_history_addr), 64'(m_hist));
            check("match_req_tag", 64'(match_req_tag), 64'(m_tag));
            check("resp_valid", 64'(resp_valid), rsp ? 64'(1) << rid : 64'(0));
            check("match_resp_ready", 64'(match_resp_ready), 64'(rrdy[rid]));
            check("resp_local_tag", 64'(resp_local_tag), 64'(rlt));
            check("resp_match_len", 64'(resp_match_len), 64'(rlen));
`ifdef SHARED_MATCH_ARB_STATS_EN
            for (int i = 0; i < NR; i++) begin
                check("stat_grant_cnt", 64'(stat_grant_cnt[i*32 +: 32]), 64'(m_sg[i]));
                check("stat_stall_cnt", 64'(stat_stall_cnt[i*32 +: 32]), 64'(m_ss[i]));
            end
`endif
        end

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (g == i) m_sg[i]++;
                else if (v[i]) m_ss[i]++;
            end
            if (load) m_valid = (g >= 0);
            if (g >= 0) begin
                m_head = heads[g];
                m_hist = hists[g];
                m_tag  = {lts[g], NUM_JOB_PE_LOG2'(g)};
                m_cnt[g]++;
                m_ptr = (g + 1) % NR;
            end
            if (rsp && rrdy[rid]) m_cnt[rid]--;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step('0, 1'b1, 1'b0, 0, '1);
        rst = 1'b0;
    endtask

    initial begin
        int pick;
        int live [$];
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step('0, 1'b1, 1'b0, 0, '1);
        step('0, 1'b1, 1'b0, 0, '1);
        rst = 1'b0;

        // Reset state and single requester 2 issuing three requests.
        step('0, 1'b1, 1'b0, 0, '1);
        for (int n = 0; n < 3; n++) step(4'b0100, 1'b1, 1'b0, 0, '1);
        step('0, 1'b1, 1'b0, 0, '1);
        step('0, 1'b1, 1'b0, 0, '1);

        // All requesters valid: strict rotation, one grant per cycle.
        do_reset();
        for (int n = 0; n < 8; n++) step(4'b1111, 1'b1, 1'b0, 0, '1);

        // Requester 1 saturates at MAX_OUTSTANDING, then one response drains it.
        do_reset();
        for (int n = 0; n < 5; n++) step(4'b0010, 1'b1, 1'b0, 0, '1);
        step(4'b0010, 1'b1, 1'b1, 1, '1);
        step(4'b0010, 1'b1, 1'b0, 0, '1);
        step(4'b0110, 1'b1, 1'b0, 0, '1);

        // Downstream stall for five cycles.
        do_reset();
        step(4'b1111, 1'b1, 1'b0, 0, '1);
        for (int n = 0; n < 5; n++) step(4'b1111, 1'b0, 1'b0, 0, '1);
        for (int n = 0; n < 3; n++) step(4'b1111, 1'b1, 1'b0, 0, '1);

        // Requester 3: same-cycle grant+response, then a refused response.
        do_reset();
        step(4'b1000, 1'b1, 1'b0, 0, '1);
        step(4'b1000, 1'b1, 1'b1, 3, '1);
        step(4'b1000, 1'b1, 1'b1, 3, 4'b0111);
        for (int n = 0; n < 4; n++) step(4'b1000, 1'b1, 1'b0, 0, '1);

        // Reset with requests in flight; pointer must restart at 0.
        do_reset();
        step(4'b1111, 1'b1, 1'b0, 0, '1);
        step(4'b1111, 1'b1, 1'b0, 0, '1);
        rst = 1'b1;
        step(4'b1111, 1'b1, 1'b0, 0, '1);
        rst = 1'b0;
        step(4'b1111, 1'b1, 1'b0, 0, '1);
        step(4'b1111, 1'b1, 1'b0, 0, '1);

        // Random traffic with legal responses only.
        for (int n = 0; n < 400; n++) begin
            live.delete();
            for (int i = 0; i < NR; i++) if (m_cnt[i] > 0) live.push_back(i);
            pick = 0;
            if (live.size() > 0) pick = live[$urandom_range(0, live.size() - 1)];
            step(NR'($urandom), $urandom_range(0, 3) != 0,
                 (live.size() > 0) && ($urandom_range(0, 2) != 0), pick, NR'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
